mem_copy_master: RTL
====================

// Module: mem_copy_master
// PURPOSE
//  Initiator for the core's word-addressed req/gnt/rvalid memory port: drives the same port
//  the instruction/data memory responds on. Copies len_i words from src_i to dst_i, one
//  transaction outstanding at a time. Used by the SoC to preload/relocate memory images and
//  to move result/flag words between regions without core involvement.
// PARAMETERS
//  ADDR_W  32  width of port address (word index, not byte address)
//  DATA_W  32  data word width
//  LEN_W   8   width of transfer length; max copy = 2**LEN_W-1 words
// PORTS
//  clk            in   1       clock, all logic on rising edge
//  rst            in   1       synchronous reset, active-high
//  start_i        in   1       launch copy; sampled only in IDLE
//  src_i          in   ADDR_W  first source word index, latched on accepted start
//  dst_i          in   ADDR_W  first destination word index, latched on accepted start
//  len_i          in   LEN_W   number of words to copy, latched on accepted start
//  busy_o         out  1       high in every state except IDLE
//  done_o         out  1       one-cycle pulse when copy finishes
//  count_o        out  LEN_W   words written so far in current/last copy
//  port_req_o     out  1       transaction request
//  port_gnt_i     in   1       responder accepted request this cycle
//  port_rvalid_i  in   1       response valid (reads and writes), >=1 cycle after gnt
//  port_addr_o    out  ADDR_W  word index
//  port_we_o      out  1       1 = write, 0 = read
//  port_rdata_i   in   DATA_W  read data, valid with port_rvalid_i
//  port_wdata_o   out  DATA_W  write data
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): state=IDLE; port_req_o=0, port_we_o=0, port_addr_o=0,
//   port_wdata_o=0, busy_o=0, done_o=0, count_o=0. Reset mid-copy abandons the copy;
//   an in-flight rvalid arriving after reset is ignored.
//  FSM: IDLE -> RD_REQ -> RD_WAIT -> WR_REQ -> WR_WAIT -> (RD_REQ | DONE) -> IDLE.
//   IDLE:    start_i=1 & len_i!=0 -> latch src/dst/len, count_o=0, go RD_REQ.
//            start_i=1 & len_i==0 -> count_o=0, go DONE (no bus traffic).
//   RD_REQ:  req=1, we=0, addr=src+count; on gnt -> RD_WAIT.
//   RD_WAIT: req=0; on rvalid capture rdata into data reg -> WR_REQ.
//   WR_REQ:  req=1, we=1, addr=dst+count, wdata=data reg; on gnt -> WR_WAIT.
//   WR_WAIT: req=0; on rvalid count+=1; if count+1==len -> DONE else RD_REQ.
//   DONE:    done_o=1 for exactly this cycle, busy_o=1; -> IDLE.
//  Handshake: req/addr/we/wdata held stable from assertion until gnt seen; req drops the
//   cycle after gnt. Never a second req before the rvalid of the previous one.
//  rvalid outside RD_WAIT/WR_WAIT is ignored. start_i while busy is ignored.
//  Address arithmetic modulo 2**ADDR_W (src/dst+count wrap to 0, no error).
//  Overlap: copy strictly ascending; dst>src overlap propagates (defined, not memmove).
//  Latency with zero-wait responder (gnt same cycle as req, rvalid next cycle): start
//   accepted at edge k -> first req in cycle k+1; N words -> done_o high in cycle k+1+4N.
//   Each gnt stall or rvalid delay cycle adds exactly one cycle.
//  count_o holds final value after DONE until next accepted start.
// TESTING
//  1. len=1, src=0x4, dst=0x10, mem[4]=0xDEADBEEF, zero-wait -> read@4, write@0x10
//     data 0xDEADBEEF, done_o pulse in cycle k+5, count_o=1.
//  2. len=4 src=0x20 dst=0x40 with random gnt stalls 0-3 cycles -> addr/we/wdata stable
//     while req&!gnt, mem[0x40..0x43]=mem[0x20..0x23], exactly 8 transactions.
//  3. len=0 start -> no port_req_o ever, done_o in cycle k+1, busy_o high 1 cycle.
//  4. src=0xFFFFFFFF len=2 -> reads at 0xFFFFFFFF then 0x0 (wrap), dst likewise.
//  5. rst asserted in RD_WAIT of word 2 of len=5 -> next cycle IDLE, req=0, count_o=0;
//     late rvalid ignored; fresh start afterwards completes normally.
//  6. start_i pulsed while busy, stray rvalid in RD_REQ -> ignored, copy result unchanged.

Source files
------------

// File: rtl/mem_copy_master_if.sv
// Word-addressed req/gnt/rvalid memory port shared by the core and the copy master.
// One outstanding transaction; rvalid answers both reads and writes.
interface mem_copy_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req;
    logic              gnt;
    logic              rvalid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] wdata;

    modport master (
        output req, addr, we, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_copy_master.sv
// Memory-to-memory word copier: reads src+i, writes dst+i, ascending, one transaction
// outstanding on the req/gnt/rvalid port.
module mem_copy_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LEN_W-1:0]  count_o,
    mem_copy_master_if.master bus
);

    typedef enum logic [2:0] {
        StIdle, StRdReq, StRdWait, StWrReq, StWrWait, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              req_c, we_c, busy_c, done_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] wdata_c;
    logic [ADDR_W-1:0] count_ext;
    logic [LEN_W-1:0]  count_inc;

    assign count_ext = ADDR_W'(count_q);
    assign count_inc = count_q + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        count_d = count_q;
        data_d  = data_q;
        req_c   = 1'b0;
        we_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        busy_c  = 1'b1;
        done_c  = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy_c = 1'b0;
                if (start_i) begin
                    count_d = '0;
                    if (len_i != '0) begin
                        src_d   = src_i;
                        dst_d   = dst_i;
                        len_d   = len_i;
                        state_d = StRdReq;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRdReq: begin
                req_c  = 1'b1;
                addr_c = src_q + count_ext;
                if (bus.gnt) state_d = StRdWait;
            end
            StRdWait: begin
                if (bus.rvalid) begin
                    data_d  = bus.rdata;
                    state_d = StWrReq;
                end
            end
            StWrReq: begin
                req_c   = 1'b1;
                we_c    = 1'b1;
                addr_c  = dst_q + count_ext;
                wdata_c = data_q;
                if (bus.gnt) state_d = StWrWait;
            end
            StWrWait: begin
                // The write response retires the word; only then does count advance.
                if (bus.rvalid) begin
                    count_d = count_inc;
                    state_d = (count_inc == len_q) ? StDone : StRdReq;
                end
            end
            StDone: begin
                done_c  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.req   = req_c;
    assign bus.we    = we_c;
    assign bus.addr  = addr_c;
    assign bus.wdata = wdata_c;
    assign busy_o    = busy_c;
    assign done_o    = done_c;
    assign count_o   = count_q;

endmodule
